// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM state encoding and owner codes.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   localparam logic OWN_DISP = 1'b0;
   localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle for the SRAM port arbiter: display port, host port, SRAM controller side and status.
interface sram_port_arbiter_if #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 32
);
   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              h_req;
   logic              h_we;
   logic [ADDR_W-1:0] h_addr;
   logic [DATA_W-1:0] h_wdata;
   logic              h_ack;
   logic [DATA_W-1:0] h_rdata;

   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic              s_read_enable;
   logic              s_write_enable;
   logic [DATA_W-1:0] s_rdata;

   logic              busy;
   logic              owner;

   modport slave (
      input  d_req, d_addr, h_req, h_we, h_addr, h_wdata, s_rdata,
      output d_ack, d_rdata, h_ack, h_rdata,
      output s_addr, s_wdata, s_read_enable, s_write_enable, busy, owner
   );

   modport master (
      output d_req, d_addr, h_req, h_we, h_addr, h_wdata, s_rdata,
      input  d_ack, d_rdata, h_ack, h_rdata,
      input  s_addr, s_wdata, s_read_enable, s_write_enable, busy, owner
   );
endinterface

// File: rtl/sram_arb_pick.sv
// Winner selection for the SRAM arbiter; display has priority unless the starvation
// guard (SRAM_ARB_STARVE_GUARD_EN) has counted MAX_CONSEC display grants while host waited.
module sram_arb_pick #(
   parameter int unsigned MAX_CONSEC = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic arb_en,
   input  logic d_req,
   input  logic h_req,
   output logic grant_valid,
   output logic grant_host
);

`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam int unsigned CW = $clog2(MAX_CONSEC + 1);

   logic [CW-1:0] consec;
   logic          force_host;

   assign force_host = (consec == CW'(MAX_CONSEC)) && h_req;

   always_comb begin
      grant_valid = d_req | h_req;
      grant_host  = h_req && (!d_req || force_host);
   end

   // Counts only display wins that left the host waiting; any other outcome restarts the run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         consec <= '0;
      end else if (arb_en && grant_valid) begin
         if (grant_host)
            consec <= '0;
         else if (h_req)
            consec <= consec + CW'(1);
         else
            consec <= '0;
      end
   end
`else
   localparam int unsigned UNUSED_MAX = MAX_CONSEC;
   logic unused_sigs;

   assign unused_sigs = ^{clk, reset, arb_en, 32'(UNUSED_MAX)};

   always_comb begin
      grant_valid = d_req | h_req;
      grant_host  = h_req && !d_req;
   end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester SRAM arbiter: display reads with fixed priority, host reads/writes,
// fixed-latency access sequencing. Optional host starvation guard: SRAM_ARB_STARVE_GUARD_EN.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W        = 20,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned MAX_CONSEC    = 4
) (
   input logic                clk,
   input logic                reset,
   sram_port_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES + 1);

   state_t            state, nstate;
   logic [CNT_W-1:0]  cnt;
   logic              owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic [DATA_W-1:0] h_rdata_q;
   logic              grant_valid;
   logic              grant_host;

   sram_arb_pick #(
      .MAX_CONSEC(MAX_CONSEC)
   ) u_pick (
      .clk        (clk),
      .reset      (reset),
      .arb_en     (state == IDLE),
      .d_req      (bus.d_req),
      .h_req      (bus.h_req),
      .grant_valid(grant_valid),
      .grant_host (grant_host)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= nstate;
   end

   always_comb begin
      nstate              = state;
      bus.s_read_enable   = 1'b0;
      bus.s_write_enable  = 1'b0;
      bus.d_ack           = 1'b0;
      bus.h_ack           = 1'b0;
      bus.busy            = (state != IDLE);
      bus.owner           = owner_q;
      bus.s_addr          = addr_q;
      bus.s_wdata         = wdata_q;
      bus.d_rdata         = d_rdata_q;
      bus.h_rdata         = h_rdata_q;
      case (state)
         IDLE: begin
            if (grant_valid)
               nstate = ISSUE;
         end
         ISSUE: begin
            bus.s_read_enable  = !we_q;
            bus.s_write_enable = we_q;
            nstate             = WAIT;
         end
         WAIT: begin
            if (cnt == '0)
               nstate = DONE;
         end
         DONE: begin
            bus.d_ack = (owner_q == OWN_DISP);
            bus.h_ack = (owner_q == OWN_HOST);
            nstate    = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   // Requests are latched once at grant; s_wdata only tracks host grants since display never writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q   <= OWN_DISP;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt       <= '0;
         d_rdata_q <= '0;
         h_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner_q <= grant_host ? OWN_HOST : OWN_DISP;
                  we_q    <= grant_host & bus.h_we;
                  addr_q  <= grant_host ? bus.h_addr : bus.d_addr;
                  if (grant_host)
                     wdata_q <= bus.h_wdata;
               end
            end
            ISSUE: cnt <= CNT_W'(ACCESS_CYCLES - 1);
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else if (!we_q) begin
                  if (owner_q == OWN_HOST)
                     h_rdata_q <= bus.s_rdata;
                  else
                     d_rdata_q <= bus.s_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: default-latency DUT plus an ACCESS_CYCLES=1 DUT.
module tb_sram_port_arbiter;
   import sram_arb_pkg::*;

   localparam int AC = 2;
`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      logic        own;
      logic [31:0] d_rd;
      logic [31:0] h_rd;
      int          ack_cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   exp_t        q[$];
   exp_t        q1[$];
   logic [31:0] m_d = '0, m_h = '0, m1_d = '0, m1_h = '0;
   logic [7:0]  hist = '0, hist1 = '0;

   sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(32)) bus();
   sram_port_arbiter_if #(.ADDR_W(20), .DATA_W(32)) bus1();

   sram_port_arbiter #(
      .ADDR_W(20), .DATA_W(32), .ACCESS_CYCLES(AC), .MAX_CONSEC(4)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   sram_port_arbiter #(
      .ADDR_W(20), .DATA_W(32), .ACCESS_CYCLES(1), .MAX_CONSEC(4)
   ) dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem(input logic [19:0] a);
      return 32'hA5A5A1A5 ^ {12'h000, a};
   endfunction

   // SRAM model: data valid only in the last WAIT cycle, garbage otherwise.
   always @(posedge clk) begin
      hist  <= {hist[6:0], bus.s_read_enable};
      hist1 <= {hist1[6:0], bus1.s_read_enable};
   end
   assign bus.s_rdata  = hist[AC-1] ? mem(bus.s_addr)  : 32'hDEADBEEF;
   assign bus1.s_rdata = hist1[0]   ? mem(bus1.s_addr) : 32'hDEADBEEF;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: actual=event required=none", name);
   endtask

   task automatic push(input logic own, input logic we, input logic [19:0] addr, input int ack_cyc);
      if (!we) begin
         if (own) m_h = mem(addr);
         else     m_d = mem(addr);
      end
      q.push_back('{own, m_d, m_h, ack_cyc});
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!reset && (bus.d_ack || bus.h_ack)) begin
         if (q.size() == 0) begin
            flag("unexpected_ack");
         end else begin
            e = q.pop_front();
            chk("ack_owner", 128'({bus.h_ack, bus.d_ack}), e.own ? 128'(2) : 128'(1));
            chk("ack_cycle", 128'(cyc), 128'(e.ack_cyc));
            chk("d_rdata", 128'(bus.d_rdata), 128'(e.d_rd));
            chk("h_rdata", 128'(bus.h_rdata), 128'(e.h_rd));
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (!reset && (bus1.d_ack || bus1.h_ack)) begin
         if (q1.size() == 0) begin
            flag("ac1_unexpected_ack");
         end else begin
            e = q1.pop_front();
            chk("ac1_ack_owner", 128'({bus1.h_ack, bus1.d_ack}), e.own ? 128'(2) : 128'(1));
            chk("ac1_ack_cycle", 128'(cyc), 128'(e.ack_cyc));
            chk("ac1_d_rdata", 128'(bus1.d_rdata), 128'(e.d_rd));
            chk("ac1_h_rdata", 128'(bus1.h_rdata), 128'(e.h_rd));
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (bus.busy && t < 20) begin @(negedge clk); t++; end
      chk("idle_before_issue", 128'(bus.busy), 128'(0));
   endtask

   task automatic wait_ack(input logic own);
      int t = 0;
      while (!(own ? bus.h_ack : bus.d_ack) && t < 30) begin @(negedge clk); t++; end
      if (t >= 30) flag("ack_timeout");
   endtask

   task automatic access(input logic own, input logic we, input logic [19:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      wait_idle();
      if (own) begin
         bus.h_req = 1'b1; bus.h_we = we; bus.h_addr = addr; bus.h_wdata = wdata;
      end else begin
         bus.d_req = 1'b1; bus.d_addr = addr;
      end
      push(own, we, addr, cyc + AC + 2);
      @(negedge clk);
      chk("strobe_issue", 128'({bus.s_read_enable, bus.s_write_enable}), we ? 128'(1) : 128'(2));
      chk("s_addr", 128'(bus.s_addr), 128'(addr));
      if (we) chk("s_wdata", 128'(bus.s_wdata), 128'(wdata));
      @(negedge clk);
      chk("strobe_wait", 128'({bus.s_read_enable, bus.s_write_enable}), 128'(0));
      chk("s_addr_hold", 128'(bus.s_addr), 128'(addr));
      wait_ack(own);
      bus.d_req = 1'b0;
      bus.h_req = 1'b0;
   endtask

   task automatic both_held();
      int c, acks, t;
      logic own;
      @(negedge clk);
      wait_idle();
      bus.d_req = 1'b1; bus.d_addr = 20'h00200;
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 20'h00300;
      c = cyc;
      for (int i = 0; i < 10; i++) begin
         own = GUARD && (i % 5 == 4);
         push(own, 1'b0, own ? 20'h00300 : 20'h00200, c + AC + 2 + 5 * i);
      end
      acks = 0;
      t = 0;
      while (acks < 10 && t < 100) begin
         @(negedge clk);
         t++;
         if (bus.d_ack || bus.h_ack) acks++;
      end
      bus.d_req = 1'b0;
      bus.h_req = 1'b0;
      if (acks < 10) flag("both_held_timeout");
   endtask

   task automatic access1(input logic own, input logic [19:0] addr);
      int t = 0;
      @(negedge clk);
      while (bus1.busy && t < 20) begin @(negedge clk); t++; end
      if (own) begin bus1.h_req = 1'b1; bus1.h_we = 1'b0; bus1.h_addr = addr; m1_h = mem(addr); end
      else     begin bus1.d_req = 1'b1; bus1.d_addr = addr; m1_d = mem(addr); end
      q1.push_back('{own, m1_d, m1_h, cyc + 3});
      t = 0;
      do begin @(negedge clk); t++; end
      while (!(own ? bus1.h_ack : bus1.d_ack) && t < 30);
      if (t >= 30) flag("ac1_ack_timeout");
      bus1.d_req = 1'b0;
      bus1.h_req = 1'b0;
   endtask

   initial begin
      bus.d_req = 1'b0; bus.d_addr = '0; bus.h_req = 1'b0; bus.h_we = 1'b0;
      bus.h_addr = '0; bus.h_wdata = '0;
      bus1.d_req = 1'b0; bus1.d_addr = '0; bus1.h_req = 1'b0; bus1.h_we = 1'b0;
      bus1.h_addr = '0; bus1.h_wdata = '0;

      repeat (3) @(negedge clk);
      chk("reset_state", 128'({bus.d_ack, bus.h_ack, bus.d_rdata, bus.h_rdata, bus.s_addr, bus.s_wdata,
                               bus.s_read_enable, bus.s_write_enable, bus.busy, bus.owner}), 128'(0));
      chk("ac1_reset_state", 128'({bus1.d_ack, bus1.h_ack, bus1.d_rdata, bus1.h_rdata, bus1.busy}), 128'(0));
      reset = 1'b0;

      access(OWN_DISP, 1'b0, 20'h00400, '0);
      access(OWN_HOST, 1'b0, 20'h00055, '0);
      access(OWN_HOST, 1'b1, 20'h00010, 32'h12345678);
      access(OWN_DISP, 1'b0, 20'h00777, '0);
      both_held();

      // Abort a host read during WAIT, then let the held request restart cleanly.
      @(negedge clk);
      wait_idle();
      bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 20'h0ABCD;
      push(OWN_HOST, 1'b0, 20'h0ABCD, cyc + AC + 2);
      @(negedge clk);
      @(negedge clk);
      chk("busy_in_wait", 128'(bus.busy), 128'(1));
      #2 reset = 1'b1;
      #1 chk("reset_midflight", 128'({bus.d_ack, bus.h_ack, bus.d_rdata, bus.h_rdata, bus.s_addr, bus.s_wdata,
                                      bus.s_read_enable, bus.s_write_enable, bus.busy, bus.owner}), 128'(0));
      void'(q.pop_back());
      m_d = '0;
      m_h = '0;
      @(negedge clk);
      reset = 1'b0;
      push(OWN_HOST, 1'b0, 20'h0ABCD, cyc + AC + 2);
      wait_ack(OWN_HOST);
      bus.h_req = 1'b0;

      access1(OWN_DISP, 20'h00400);
      access1(OWN_HOST, 20'h00099);

      repeat (6) @(negedge clk);
      chk("scoreboard_drained", 128'(q.size()), 128'(0));
      chk("ac1_scoreboard_drained", 128'(q1.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
